// File: rtl/uart_command_host.sv
// Host-side command initiator: serialises one command into UART frame bytes,
// then assembles the response or reports a receive error / response timeout.
module uart_command_host #(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_FILE_DEPTH = 16,
    parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   command_valid,
    output logic                                   command_ready,
    input  logic [1:0]                             command_type,
    input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] command_address,
    input  logic [DATA_WIDTH-1:0]                  command_data_A,
    input  logic [DATA_WIDTH-1:0]                  command_data_B,
    input  logic [3:0]                             command_function,
    output logic                                   transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]                  transmitter_parallel_data,
    input  logic                                   transmitter_ready,
    input  logic                                   receiver_parallel_data_valid,
    input  logic [DATA_WIDTH-1:0]                  receiver_parallel_data,
    input  logic                                   receiver_error,
    output logic                                   response_valid,
    output logic [2*DATA_WIDTH-1:0]                response_data,
    output logic                                   response_error,
    output logic                                   response_timeout
);
    localparam int unsigned ADDR_W = $clog2(REGISTER_FILE_DEPTH);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] T_WRITE  = 2'd0;
    localparam logic [1:0] T_READ   = 2'd1;
    localparam logic [1:0] T_ALU_OP = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RESP, S_DONE} state_t;

    state_t                  r_state, w_state_next;
    logic [1:0]              r_type, w_type_n;
    logic [ADDR_W-1:0]       r_addr, w_addr_n;
    logic [DATA_WIDTH-1:0]   r_data_a, w_data_a_n, r_data_b, w_data_b_n;
    logic [3:0]              r_func, w_func_n;
    logic [1:0]              r_tx_idx, w_tx_idx_n;
    logic                    r_rx_idx, w_rx_idx_n;
    logic [CNT_W-1:0]        r_count, w_count_n;
    logic                    r_cmd_ready, w_cmd_ready_n;
    logic                    r_tx_valid, w_tx_valid_n;
    logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data_n;
    logic                    r_resp_valid, w_resp_valid_n;
    logic [2*DATA_WIDTH-1:0] r_resp_data, w_resp_data_n;
    logic                    r_resp_error, w_resp_error_n;
    logic                    r_resp_timeout, w_resp_timeout_n;
    logic                    w_accept, w_tx_fire, w_tx_last, w_rx_last, w_timeout_hit;

    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]            typ,
        input logic [1:0]            idx,
        input logic [ADDR_W-1:0]     addr,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            fn
    );
        logic [DATA_WIDTH-1:0] w_byte;
        w_byte = '0;
        case (typ)
            T_WRITE:  w_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hAA) :
                               (idx == 2'd1) ? DATA_WIDTH'(addr) : a;
            T_READ:   w_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(addr);
            T_ALU_OP: w_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hCC) :
                               (idx == 2'd1) ? a :
                               (idx == 2'd2) ? b : DATA_WIDTH'(fn);
            default:  w_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(fn);
        endcase
        return w_byte;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] typ);
        case (typ)
            T_WRITE:  return 2'd2;
            T_ALU_OP: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

    assign w_accept      = command_valid && r_cmd_ready;
    assign w_tx_fire     = r_tx_valid && transmitter_ready;
    assign w_tx_last     = (r_tx_idx == last_idx(r_type));
    assign w_rx_last     = (r_type == T_READ) || r_rx_idx;
    // Terminal count is registered so the pulse lands as the counter reaches TIMEOUT_CYCLES-1
    assign w_timeout_hit = (r_count == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_SEND;
            S_SEND: if (w_tx_fire && w_tx_last)
                        w_state_next = (r_type == T_WRITE) ? S_DONE : S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (receiver_parallel_data_valid) begin
                    if (receiver_error) w_state_next = S_IDLE;
                    else if (w_rx_last) w_state_next = S_DONE;
                end else if (w_timeout_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_type_n = r_type;  w_addr_n = r_addr;  w_data_a_n = r_data_a;
        w_data_b_n = r_data_b;  w_func_n = r_func;
        w_tx_idx_n = r_tx_idx;  w_rx_idx_n = r_rx_idx;  w_count_n = r_count;
        w_cmd_ready_n = r_cmd_ready;  w_tx_valid_n = r_tx_valid;  w_tx_data_n = r_tx_data;
        w_resp_data_n = r_resp_data;
        w_resp_valid_n = 1'b0;  w_resp_error_n = 1'b0;  w_resp_timeout_n = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_type_n = command_type;  w_addr_n = command_address;
                w_data_a_n = command_data_A;  w_data_b_n = command_data_B;
                w_func_n = command_function;
                w_tx_idx_n = '0;  w_rx_idx_n = 1'b0;  w_resp_data_n = '0;
                w_cmd_ready_n = 1'b0;  w_tx_valid_n = 1'b1;
                w_tx_data_n = frame_byte(command_type, 2'd0, command_address,
                                         command_data_A, command_data_B, command_function);
            end
            S_SEND: if (w_tx_fire) begin
                if (w_tx_last) begin
                    w_tx_valid_n = 1'b0;  w_tx_data_n = '0;  w_tx_idx_n = '0;
                    w_count_n = '0;
                    w_resp_valid_n = (r_type == T_WRITE);
                end else begin
                    w_tx_idx_n  = r_tx_idx + 2'd1;
                    w_tx_data_n = frame_byte(r_type, r_tx_idx + 2'd1, r_addr,
                                             r_data_a, r_data_b, r_func);
                end
            end
            S_WAIT_RESP: begin
                // A received byte always beats a coincident terminal count
                if (receiver_parallel_data_valid) begin
                    w_count_n = '0;
                    if (receiver_error) begin
                        w_resp_error_n = 1'b1;  w_resp_data_n = '0;  w_cmd_ready_n = 1'b1;
                    end else begin
                        if (r_rx_idx) w_resp_data_n[2*DATA_WIDTH-1:DATA_WIDTH] = receiver_parallel_data;
                        else          w_resp_data_n[DATA_WIDTH-1:0] = receiver_parallel_data;
                        if (r_type == T_READ) w_resp_data_n[2*DATA_WIDTH-1:DATA_WIDTH] = '0;
                        if (w_rx_last) w_resp_valid_n = 1'b1;
                        else           w_rx_idx_n = 1'b1;
                    end
                end else begin
                    w_count_n = r_count + CNT_W'(1);
                    if (w_timeout_hit) begin
                        w_resp_timeout_n = 1'b1;  w_resp_data_n = '0;  w_cmd_ready_n = 1'b1;
                    end
                end
            end
            default: w_cmd_ready_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_type <= '0;  r_addr <= '0;  r_data_a <= '0;  r_data_b <= '0;  r_func <= '0;
            r_tx_idx <= '0;  r_rx_idx <= 1'b0;  r_count <= '0;
            r_cmd_ready <= 1'b1;  r_tx_valid <= 1'b0;  r_tx_data <= '0;
            r_resp_valid <= 1'b0;  r_resp_data <= '0;
            r_resp_error <= 1'b0;  r_resp_timeout <= 1'b0;
        end else begin
            r_type <= w_type_n;  r_addr <= w_addr_n;  r_data_a <= w_data_a_n;
            r_data_b <= w_data_b_n;  r_func <= w_func_n;
            r_tx_idx <= w_tx_idx_n;  r_rx_idx <= w_rx_idx_n;  r_count <= w_count_n;
            r_cmd_ready <= w_cmd_ready_n;  r_tx_valid <= w_tx_valid_n;  r_tx_data <= w_tx_data_n;
            r_resp_valid <= w_resp_valid_n;  r_resp_data <= w_resp_data_n;
            r_resp_error <= w_resp_error_n;  r_resp_timeout <= w_resp_timeout_n;
        end
    end

    assign command_ready                   = r_cmd_ready;
    assign transmitter_parallel_data_valid = r_tx_valid;
    assign transmitter_parallel_data       = r_tx_data;
    assign response_valid                  = r_resp_valid;
    assign response_data                   = r_resp_data;
    assign response_error                  = r_resp_error;
    assign response_timeout                = r_resp_timeout;
endmodule

// File: tb/tb_uart_command_host.sv
// Bench for uart_command_host: table of full command transactions plus
// hand-written timeout, receive-error and mid-operation reset sequences.
module tb_uart_command_host;
    logic        clk, rst_n;
    logic        cmd_valid, cmd_valid16;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr, cmd_fn;
    logic [7:0]  cmd_a, cmd_b;
    logic        tx_ready, rx_valid, rx_err;
    logic [7:0]  rx_data;

    logic        cmd_ready, tx_valid, resp_valid, resp_err, resp_to;
    logic [7:0]  tx_data;
    logic [15:0] resp_data;
    logic        cmd_ready2, tx_valid2, resp_valid2, resp_err2, resp_to2;
    logic [7:0]  tx_data2;
    logic [15:0] resp_data2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  a, b;
        logic [3:0]  fn;
        int          nbytes;
        logic [31:0] bytes;     // frame bytes, first byte in [7:0]
        bit          toggle;    // transmitter_ready alternates 0/1
        int          delay;     // idle cycles before the reply
        int          nreply;
        logic [15:0] reply;     // reply bytes, first byte in [7:0]
        logic [15:0] exp_resp;
    } vec_t;

    uart_command_host dut (
        .clk(clk), .reset(rst_n),
        .command_valid(cmd_valid), .command_ready(cmd_ready),
        .command_type(cmd_type), .command_address(cmd_addr),
        .command_data_A(cmd_a), .command_data_B(cmd_b), .command_function(cmd_fn),
        .transmitter_parallel_data_valid(tx_valid), .transmitter_parallel_data(tx_data),
        .transmitter_ready(tx_ready),
        .receiver_parallel_data_valid(rx_valid), .receiver_parallel_data(rx_data),
        .receiver_error(rx_err),
        .response_valid(resp_valid), .response_data(resp_data),
        .response_error(resp_err), .response_timeout(resp_to)
    );

    uart_command_host #(.TIMEOUT_CYCLES(16)) dut16 (
        .clk(clk), .reset(rst_n),
        .command_valid(cmd_valid16), .command_ready(cmd_ready2),
        .command_type(cmd_type), .command_address(cmd_addr),
        .command_data_A(cmd_a), .command_data_B(cmd_b), .command_function(cmd_fn),
        .transmitter_parallel_data_valid(tx_valid2), .transmitter_parallel_data(tx_data2),
        .transmitter_ready(tx_ready),
        .receiver_parallel_data_valid(rx_valid), .receiver_parallel_data(rx_data),
        .receiver_error(rx_err),
        .response_valid(resp_valid2), .response_data(resp_data2),
        .response_error(resp_err2), .response_timeout(resp_to2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit sel16, input logic [1:0] typ, input logic [3:0] addr,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
        cmd_type = typ; cmd_addr = addr; cmd_a = a; cmd_b = b; cmd_fn = fn;
        if (sel16) cmd_valid16 = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_valid16 = 1'b0;
    endtask

    // Ends on the negedge of the cycle after the last frame byte transferred
    task automatic drain(input bit sel16);
        int g = 0;
        tx_ready = 1'b1;
        while ((sel16 ? tx_valid2 : tx_valid) && g < 20) begin
            @(negedge clk); g++;
        end
        tx_ready = 1'b0;
        check("drain_done", 32'(sel16 ? tx_valid2 : tx_valid), 0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int k = 0;
        int g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        check($sformatf("v%0d_ready_idle", id), 32'(cmd_ready), 1);
        issue(1'b0, v.typ, v.addr, v.a, v.b, v.fn);
        check($sformatf("v%0d_ready_drop", id), 32'(cmd_ready), 0);
        g = 0;
        while (k < v.nbytes && g < 64) begin
            check($sformatf("v%0d_tx_valid%0d", id, k), 32'(tx_valid), 1);
            check($sformatf("v%0d_tx_byte%0d", id, k), 32'(tx_data), 32'(v.bytes[8*k +: 8]));
            tx_ready = v.toggle ? g[0] : 1'b1;
            @(posedge clk);
            if (tx_ready) k++;
            @(negedge clk);
            g++;
        end
        tx_ready = 1'b0;
        check($sformatf("v%0d_tx_idle", id), 32'(tx_valid), 0);
        if (v.typ != 2'd0) begin
            check($sformatf("v%0d_no_early_resp", id), 32'(resp_valid), 0);
            repeat (v.delay) @(negedge clk);
            for (int i = 0; i < v.nreply; i++) begin
                rx_valid = 1'b1; rx_err = 1'b0; rx_data = v.reply[8*i +: 8];
                @(posedge clk); @(negedge clk);
            end
            rx_valid = 1'b0;
        end
        check($sformatf("v%0d_resp_valid", id), 32'(resp_valid), 1);
        check($sformatf("v%0d_resp_data", id), 32'(resp_data), 32'(v.exp_resp));
        check($sformatf("v%0d_busy_in_done", id), 32'(cmd_ready), 0);
        @(negedge clk);
        check($sformatf("v%0d_resp_pulse_end", id), 32'(resp_valid), 0);
        check($sformatf("v%0d_ready_back", id), 32'(cmd_ready), 1);
        check($sformatf("v%0d_resp_hold", id), 32'(resp_data), 32'(v.exp_resp));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   bad;
        vecs[0] = '{2'd0, 4'd5, 8'h3C, 8'h00, 4'h0, 3, 32'h003C05AA, 1'b0, 0,  0, 16'h0000, 16'h0000};
        vecs[1] = '{2'd1, 4'd2, 8'h00, 8'h00, 4'h0, 2, 32'h000002BB, 1'b0, 40, 1, 16'h0081, 16'h0081};
        vecs[2] = '{2'd2, 4'd0, 8'h12, 8'h34, 4'h2, 4, 32'h023412CC, 1'b1, 0,  2, 16'h0368, 16'h0368};
        vecs[3] = '{2'd3, 4'd0, 8'h00, 8'h00, 4'h7, 2, 32'h000007DD, 1'b0, 3,  2, 16'hCDAB, 16'hCDAB};
        vecs[4] = '{2'd1, 4'hF, 8'hEE, 8'h11, 4'h9, 2, 32'h00000FBB, 1'b1, 1,  1, 16'h00FF, 16'h00FF};
        vecs[5] = '{2'd0, 4'h0, 8'hFF, 8'h00, 4'h0, 3, 32'h00FF00AA, 1'b1, 0,  0, 16'h0000, 16'h0000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid16 = 1'b0; cmd_type = '0; cmd_addr = '0;
        cmd_a = '0; cmd_b = '0; cmd_fn = '0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_resp_error", 32'(resp_err), 0);
        check("rst_resp_timeout", 32'(resp_to), 0);
        check("rst_cmd_ready16", 32'(cmd_ready2), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Timeout: pulse exactly 16 cycles after the last frame byte
        issue(1'b1, 2'd3, 4'd0, 8'h00, 8'h00, 4'h0);
        check("to_byte0", 32'(tx_data2), 32'h0DD);
        tx_ready = 1'b1;
        @(negedge clk);
        check("to_byte1", 32'(tx_data2), 32'h000);
        check("to_byte1_valid", 32'(tx_valid2), 1);
        @(negedge clk);
        tx_ready = 1'b0;
        check("to_tx_idle", 32'(tx_valid2), 0);
        bad = 0;
        for (int j = 1; j <= 15; j++) begin
            if (resp_to2 || resp_valid2) bad++;
            @(negedge clk);
        end
        check("to_no_early_pulse", 32'(bad), 0);
        check("to_pulse", 32'(resp_to2), 1);
        check("to_no_valid", 32'(resp_valid2), 0);
        check("to_data_clear", 32'(resp_data2), 0);
        check("to_ready", 32'(cmd_ready2), 1);
        @(negedge clk);
        check("to_pulse_end", 32'(resp_to2), 0);

        // Byte on the terminal-count cycle wins over the timeout
        issue(1'b1, 2'd1, 4'd1, 8'h00, 8'h00, 4'h0);
        drain(1'b1);
        repeat (14) @(negedge clk);
        rx_valid = 1'b1; rx_err = 1'b0; rx_data = 8'h5A;
        @(posedge clk); @(negedge clk);
        rx_valid = 1'b0;
        check("win_valid", 32'(resp_valid2), 1);
        check("win_no_timeout", 32'(resp_to2), 0);
        check("win_data", 32'(resp_data2), 32'h005A);
        @(negedge clk);
        check("win_no_late_timeout", 32'(resp_to2), 0);
        check("win_ready", 32'(cmd_ready2), 1);

        // Receive error on a REG_READ reply, then a stray byte while idle
        issue(1'b0, 2'd1, 4'd3, 8'h00, 8'h00, 4'h0);
        drain(1'b0);
        rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'h55;
        @(posedge clk); @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0;
        check("err_pulse", 32'(resp_err), 1);
        check("err_data", 32'(resp_data), 0);
        check("err_ready", 32'(cmd_ready), 1);
        check("err_no_valid", 32'(resp_valid), 0);
        rx_valid = 1'b1; rx_data = 8'h77;
        @(posedge clk); @(negedge clk);
        rx_valid = 1'b0;
        check("stray_err_end", 32'(resp_err), 0);
        check("stray_no_valid", 32'(resp_valid), 0);
        check("stray_ready", 32'(cmd_ready), 1);
        check("stray_no_tx", 32'(tx_valid), 0);

        // Error on the second ALU byte discards the already stored first byte
        issue(1'b0, 2'd3, 4'd0, 8'h00, 8'h00, 4'h1);
        drain(1'b0);
        rx_valid = 1'b1; rx_err = 1'b0; rx_data = 8'h99;
        @(posedge clk); @(negedge clk);
        rx_err = 1'b1; rx_data = 8'hAA;
        @(posedge clk); @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0;
        check("err2_pulse", 32'(resp_err), 1);
        check("err2_data_clear", 32'(resp_data), 0);
        check("err2_no_valid", 32'(resp_valid), 0);

        // Reset while the third ALU_WITH_OPERANDS byte is on the bus
        tx_ready = 1'b1;
        issue(1'b0, 2'd2, 4'd0, 8'h12, 8'h34, 4'h2);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_third_byte", 32'(tx_data), 32'h34);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", 32'(tx_valid), 0);
        check("rst_mid_tx_data", 32'(tx_data), 0);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        check("rst_mid_pulses", 32'({resp_valid, resp_err, resp_to}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        rv = '{2'd1, 4'd9, 8'h00, 8'h00, 4'h0, 2, 32'h000009BB, 1'b0, 2, 1, 16'h00C3, 16'h00C3};
        run_vec(rv, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
